alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
Sequential execution unit that consumes the 3-bit ALUControl code produced by the ALU decoder, together with two operands. It produces a registered result and zero flag over a valid/ready handshake. Add, sub, and, or and slt complete in one cycle. The shift codes (100/110/111) are executed iteratively, one bit per cycle. This block is the consumer end of the ALUControl interface and sits between operand select and writeback in the multi-cycle datapath extension.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of 2, minimum 8.
- SHAMT_W, $clog2(WIDTH), number of low src_b bits used as the shift amount.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; returns the unit to IDLE.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- alu_control  input  3  operation code; see Behaviour.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B; also carries the shift amount in bits [SHAMT_W-1:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered (result == 0).

Behaviour:
- Reset is asynchronous: state=IDLE, out_valid=0, result=0, zero=0, shift register=0, counter=0.
- Operation codes:
  - 000 add: a+b mod 2^WIDTH.
  - 001 sub: a-b mod 2^WIDTH.
  - 010 and.
  - 011 or.
  - 101 slt: signed a<b gives 1, else 0, zero-extended.
  - 100 sll.
  - 110 srl: logical right shift.
  - 111 sra: arithmetic right shift, sign bit replicated.
- All codes are legal. No carry or overflow outputs.
- in_ready = (state==IDLE). A request is accepted when in_valid && in_ready. alu_control, src_a and src_b are sampled only at acceptance.
- States:
  - IDLE:
    - Non-shift op accepted: result and zero loaded at the same edge -> DONE.
    - Shift op accepted: shreg=src_a, cnt=src_b[SHAMT_W-1:0], op latched. If cnt==0, result=src_a and zero is computed -> DONE. Otherwise -> SHIFT.
  - SHIFT:
    - Each cycle, shreg shifts by 1 in the latched direction (sra refills with shreg[WIDTH-1]) and cnt decrements.
    - When cnt==1, the final shifted value is written to result and zero -> DONE.
  - DONE:
    - out_valid=1. result and zero are held stable.
    - On out_ready -> IDLE. out_valid drops and in_ready rises on the next cycle.
- Latency from the acceptance edge to out_valid high:
  - Non-shift ops and shift with amount 0: 1 cycle.
  - Shift by N (N>0): 1+N cycles.
- Throughput is at most one result per 2 cycles. There is no same-cycle accept on output handshake.
- Backpressure: out_valid stays asserted and result is frozen for any number of cycles while out_ready=0.
- in_valid while not in IDLE is ignored; in_ready=0 in that case. A request is never dropped silently: the requester must hold it.
- flush has priority over every other event in the same cycle, including acceptance and output handshake. Effects: state=IDLE, out_valid=0, cnt=0. result and zero keep their last value. In-flight work is discarded.
- Only shift-amount bits [SHAMT_W-1:0] are used; upper src_b bits are ignored for shifts.
- out_valid is never asserted in IDLE or SHIFT.

Test Plan:
1. Reset and basic ops:
   - Reset -> in_ready=1, out_valid=0, result=0, zero=0.
   - add 0x7FFFFFFF+0x00000001 -> out_valid 1 cycle after accept, result 0x80000000, zero=0.
2. sub and slt:
   - sub 5-5 -> result 0, zero=1.
   - slt a=0xFFFFFFFF (−1), b=1 -> result 1.
   - slt a=1, b=0xFFFFFFFF -> result 0, zero=1.
3. Shift latency:
   - sll a=0x1, b=31 -> out_valid exactly 32 cycles after accept, result 0x80000000.
   - srl a=0x80000000, b=4 -> 0x08000000 at 5 cycles.
   - sra same operands -> 0xF8000000.
   - sll b=0x20 (amount 0) -> result=a at 1 cycle.
4. Backpressure:
   - out_ready held 0 for 10 cycles -> out_valid and result stable, in_ready=0.
   - A new in_valid during those cycles is not accepted.
   - Once out_ready=1 -> IDLE, the new request is accepted on the following cycle.
5. Flush:
   - flush asserted in the 3rd cycle of an sra by 20 -> next cycle state IDLE, out_valid=0, in_ready=1.
   - A following and 0xF0F0&0x0FF0 -> 0x00F0.
6. Async reset mid-operation:
   - rst_n dropped mid-SHIFT, not clock-aligned -> outputs reach reset values immediately.
   - After release, the first request behaves normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit: single-cycle add/sub/and/or/slt, bit-serial shifts,
// valid/ready handshake on both sides with a registered result and zero flag.
module alu_exec_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         alu_control,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b101;

   // Latched shift direction is alu_control[1:0]: 00 sll, 10 srl, 11 sra.
   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b10;

   state_t               state, state_n;
   logic [WIDTH-1:0]     shreg, shreg_n;
   logic [SHAMT_W-1:0]   cnt, cnt_n;
   logic [1:0]           sh_op, sh_op_n;
   logic [WIDTH-1:0]     result_n;
   logic                 zero_n;
   logic                 out_valid_n;
   logic                 in_ready_n;

   logic                 is_shift_c;
   logic                 slt_c;
   logic [WIDTH-1:0]     alu_res_c;
   logic [WIDTH-1:0]     shifted_c;
   logic [SHAMT_W-1:0]   amt_c;

   // Single-cycle datapath for the non-shift codes.
   always_comb begin
      slt_c     = $signed(src_a) < $signed(src_b);
      alu_res_c = '0;
      case (alu_control)
         OP_ADD:  alu_res_c = src_a + src_b;
         OP_SUB:  alu_res_c = src_a - src_b;
         OP_AND:  alu_res_c = src_a & src_b;
         OP_OR:   alu_res_c = src_a | src_b;
         OP_SLT:  alu_res_c = {{(WIDTH-1){1'b0}}, slt_c};
         default: alu_res_c = '0;
      endcase
   end

   assign is_shift_c = alu_control[2] && (alu_control != OP_SLT);
   assign amt_c      = src_b[SHAMT_W-1:0];

   // One-bit step of the iterative shifter.
   always_comb begin
      case (sh_op)
         SH_SLL:  shifted_c = {shreg[WIDTH-2:0], 1'b0};
         SH_SRL:  shifted_c = {1'b0, shreg[WIDTH-1:1]};
         default: shifted_c = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      endcase
   end

   // Next-state and datapath-register update; flush overrides everything.
   always_comb begin
      state_n  = state;
      shreg_n  = shreg;
      cnt_n    = cnt;
      sh_op_n  = sh_op;
      result_n = result;
      zero_n   = zero;

      if (flush) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (is_shift_c) begin
                     shreg_n = src_a;
                     cnt_n   = amt_c;
                     sh_op_n = alu_control[1:0];
                     if (amt_c == '0) begin
                        result_n = src_a;
                        zero_n   = (src_a == '0);
                        state_n  = DONE;
                     end else begin
                        state_n  = SHIFT;
                     end
                  end else begin
                     result_n = alu_res_c;
                     zero_n   = (alu_res_c == '0);
                     state_n  = DONE;
                  end
               end
            end
            SHIFT: begin
               shreg_n = shifted_c;
               cnt_n   = cnt - SHAMT_W'(1);
               if (cnt == SHAMT_W'(1)) begin
                  result_n = shifted_c;
                  zero_n   = (shifted_c == '0);
                  state_n  = DONE;
               end
            end
            DONE: begin
               if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end

      out_valid_n = (state_n == DONE);
      in_ready_n  = (state_n == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         sh_op     <= SH_SLL;
         result    <= '0;
         zero      <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         cnt       <= cnt_n;
         sh_op     <= sh_op_n;
         result    <= result_n;
         zero      <= zero_n;
         out_valid <= out_valid_n;
         in_ready  <= in_ready_n;
      end
   end

endmodule
